// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall encodings,
// FSM state type, counter widths and a saturating increment helper.
package pipe_ctrl_pkg;

   localparam int unsigned CNT_W  = 6;
   localparam int unsigned PERF_W = 32;

   // Per pipeline register control: {downstream held, upstream held}
   localparam logic [1:0] STALL_LOAD   = 2'b00;
   localparam logic [1:0] STALL_BUBBLE = 2'b01;
   localparam logic [1:0] STALL_HOLD   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MC_BUSY  = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_e;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + PERF_W'(1);
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between the ID sources and the EX load destination.
module hazard_detect #(
   parameter int unsigned REG_AW = 5
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_use,
   input  logic              id_rs2_use,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_reg_waddr,
   output logic              load_use_c
);

   // Register 0 is hardwired, so a load targeting it never creates a hazard
   always_comb begin
      load_use_c = ex_is_load && (ex_reg_waddr != '0) &&
                   ((id_rs1_use && (id_rs1 == ex_reg_waddr)) ||
                    (id_rs2_use && (id_rs2 == ex_reg_waddr)));
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory wait > multi-cycle EX > branch flush > load-use.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MC_MAX_CYCLES = 34,
   parameter int unsigned REG_AW        = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_use,
   input  logic              id_rs2_use,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_reg_waddr,
   input  logic              ex_mc_start,
   input  logic              ex_mc_done,
   input  logic              ex_branch_taken,
   input  logic              mem_req,
   input  logic              mem_ack,
   output logic              pc_hold,
   output logic [1:0]        stall_if_id,
   output logic [1:0]        stall_id_ex,
   output logic [1:0]        stall_ex_mem,
   output logic [1:0]        stall_mem_wb,
`ifdef PIPE_CTRL_PERF_EN
   output logic [PERF_W-1:0] perf_mem_stall,
   output logic [PERF_W-1:0] perf_mc_stall,
   output logic [PERF_W-1:0] perf_flush,
   output logic [PERF_W-1:0] perf_loaduse,
`endif
   output logic              mc_timeout
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_MAX_CYCLES - 1);

   state_e           state;
   logic [CNT_W-1:0] busy_cnt;
   logic             load_use_c;
   logic             mem_wait_c;
   logic             mc_act_c;
   logic             flush_c;
   logic             lu_act_c;
   logic             h_if, h_id, h_ex, h_mem;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard (
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_use   (id_rs1_use),
      .id_rs2_use   (id_rs2_use),
      .ex_is_load   (ex_is_load),
      .ex_reg_waddr (ex_reg_waddr),
      .load_use_c   (load_use_c)
   );

   // Operation tracking; a memory wait inside MC_BUSY does not disturb the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         busy_cnt   <= '0;
         mc_timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_req && !mem_ack) begin
                  state <= ST_MEM_WAIT;
               end else if (ex_mc_start && !ex_mc_done) begin
                  state    <= ST_MC_BUSY;
                  busy_cnt <= '0;
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ack) state <= ST_IDLE;
            end
            ST_MC_BUSY: begin
               busy_cnt <= busy_cnt + CNT_W'(1);
               if (ex_mc_done) begin
                  state <= ST_IDLE;
               end else if (busy_cnt == CNT_LAST) begin
                  state      <= ST_IDLE;
                  mc_timeout <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Priority mux; a masked branch stays asserted upstream and wins once stalls clear
   always_comb begin
      mem_wait_c = 1'b0;
      mc_act_c   = 1'b0;
      flush_c    = 1'b0;
      lu_act_c   = 1'b0;
      h_if       = 1'b0;
      h_id       = 1'b0;
      h_ex       = 1'b0;
      h_mem      = 1'b0;
      if (rst_n) begin
         if (mem_req && !mem_ack) begin
            mem_wait_c = 1'b1;
         end else if (!ex_mc_done &&
                      ((state == ST_MC_BUSY) || ((state == ST_IDLE) && ex_mc_start))) begin
            mc_act_c = 1'b1;
         end else if (ex_branch_taken) begin
            flush_c = 1'b1;
         end else if (load_use_c) begin
            lu_act_c = 1'b1;
         end
      end
      h_if  = mem_wait_c | mc_act_c | lu_act_c;
      h_id  = mem_wait_c | mc_act_c | lu_act_c;
      h_ex  = mem_wait_c | mc_act_c;
      h_mem = mem_wait_c;
      pc_hold      = h_if;
      stall_if_id  = flush_c ? STALL_BUBBLE : {h_id, h_if};
      stall_id_ex  = flush_c ? STALL_BUBBLE : {h_ex, h_id};
      stall_ex_mem = {h_mem, h_ex};
      stall_mem_wb = {1'b0, h_mem};
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_mem_stall <= '0;
         perf_mc_stall  <= '0;
         perf_flush     <= '0;
         perf_loaduse   <= '0;
      end else begin
         if (mem_wait_c) perf_mem_stall <= sat_inc(perf_mem_stall);
         if (mc_act_c)   perf_mc_stall  <= sat_inc(perf_mc_stall);
         if (flush_c)    perf_flush     <= sat_inc(perf_flush);
         if (lu_act_c)   perf_loaduse   <= sat_inc(perf_loaduse);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table plus multi-cycle sequences.
module tb_pipe_ctrl;

   typedef struct {
      logic [4:0] rs1, rs2;
      logic       u1, u2, ld;
      logic [4:0] wa;
      logic       st, dn, br, mr, ma;
   } in_t;

   typedef struct {
      logic       ph;
      logic [1:0] if_id, id_ex, ex_mem, mem_wb;
      logic       to;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_reg_waddr;
   logic       id_rs1_use, id_rs2_use, ex_is_load;
   logic       ex_mc_start, ex_mc_done, ex_branch_taken, mem_req, mem_ack;
   logic       pc_hold, mc_timeout;
   logic [1:0] stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_mem_stall, perf_mc_stall, perf_flush, perf_loaduse;
`endif

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   pipe_ctrl #(.MC_MAX_CYCLES(34), .REG_AW(5)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_rs1_use      (id_rs1_use),
      .id_rs2_use      (id_rs2_use),
      .ex_is_load      (ex_is_load),
      .ex_reg_waddr    (ex_reg_waddr),
      .ex_mc_start     (ex_mc_start),
      .ex_mc_done      (ex_mc_done),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ack         (mem_ack),
      .pc_hold         (pc_hold),
      .stall_if_id     (stall_if_id),
      .stall_id_ex     (stall_id_ex),
      .stall_ex_mem    (stall_ex_mem),
      .stall_mem_wb    (stall_mem_wb),
`ifdef PIPE_CTRL_PERF_EN
      .perf_mem_stall  (perf_mem_stall),
      .perf_mc_stall   (perf_mc_stall),
      .perf_flush      (perf_flush),
      .perf_loaduse    (perf_loaduse),
`endif
      .mc_timeout      (mc_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic in_t mk_in(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic ld,
                                 input logic [4:0] wa, input logic st, input logic dn,
                                 input logic br, input logic mr, input logic ma);
      in_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ld = ld; v.wa = wa;
      v.st = st; v.dn = dn; v.br = br; v.mr = mr; v.ma = ma;
      return v;
   endfunction

   function automatic exp_t mk_exp(input logic ph, input logic [1:0] a, input logic [1:0] b,
                                   input logic [1:0] c, input logic [1:0] d, input logic to);
      exp_t e;
      e.ph = ph; e.if_id = a; e.id_ex = b; e.ex_mem = c; e.mem_wb = d; e.to = to;
      return e;
   endfunction

   function automatic exp_t e_none(input logic to); return mk_exp(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, to); endfunction
   function automatic exp_t e_lu  (input logic to); return mk_exp(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, to); endfunction
   function automatic exp_t e_br  (input logic to); return mk_exp(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, to); endfunction
   function automatic exp_t e_mc  (input logic to); return mk_exp(1'b1, 2'b11, 2'b11, 2'b01, 2'b00, to); endfunction
   function automatic exp_t e_mem (input logic to); return mk_exp(1'b1, 2'b11, 2'b11, 2'b11, 2'b01, to); endfunction

   task automatic drive(input in_t v);
      id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_use = v.u1; id_rs2_use = v.u2;
      ex_is_load = v.ld; ex_reg_waddr = v.wa; ex_mc_start = v.st; ex_mc_done = v.dn;
      ex_branch_taken = v.br; mem_req = v.mr; mem_ack = v.ma;
   endtask

   task automatic check(input string name);
      exp_t       e;
      logic [9:0] act, req;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got no expectation required one", name);
      end else begin
         e   = sb_q.pop_front();
         act = {pc_hold, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, mc_timeout};
         req = {e.ph, e.if_id, e.id_ex, e.ex_mem, e.mem_wb, e.to};
         if (act !== req) begin
            n_fail++;
            $display("FAIL %s: {pc_hold,if_id,id_ex,ex_mem,mem_wb,to} got %b required %b",
                     name, act, req);
         end
      end
   endtask

   task automatic apply(input in_t v, input exp_t e, input string name);
      @(posedge clk);
      #1;
      drive(v);
      sb_q.push_back(e);
      @(negedge clk);
      check(name);
   endtask

   vec_t tbl[14];
   in_t  z;

   initial begin
      z = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e_none(0)};
      tbl[1]  = '{mk_in(5, 0, 1, 0, 1, 5, 0, 0, 0, 0, 0), e_lu(0)};
      tbl[2]  = '{mk_in(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), e_none(0)};
      tbl[3]  = '{mk_in(3, 9, 1, 1, 1, 9, 0, 0, 0, 0, 0), e_lu(0)};
      tbl[4]  = '{mk_in(3, 9, 1, 0, 1, 9, 0, 0, 0, 0, 0), e_none(0)};
      tbl[5]  = '{mk_in(7, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0), e_none(0)};
      tbl[6]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), e_br(0)};
      tbl[7]  = '{mk_in(5, 0, 1, 0, 1, 5, 0, 0, 1, 0, 0), e_br(0)};
      tbl[8]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), e_mem(0)};
      tbl[9]  = '{mk_in(5, 0, 1, 0, 1, 5, 0, 0, 1, 1, 0), e_mem(0)};
      tbl[10] = '{mk_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), e_none(0)};
      tbl[11] = '{mk_in(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), e_br(0)};
      tbl[12] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), e_none(0)};
      tbl[13] = '{mk_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), e_none(0)};

      // Reset state, with inputs that would otherwise stall
      rst_n = 1'b0;
      drive(mk_in(5, 0, 1, 0, 1, 5, 1, 0, 1, 1, 0));
      #3;
      sb_q.push_back(e_none(0));
      check("reset_outputs");
      drive(z);
      #9 rst_n = 1'b1;

      for (int i = 0; i < 14; i++) apply(tbl[i].i, tbl[i].e, $sformatf("vec%0d", i));

      // Multi-cycle op completing 10 cycles after the start pulse
      apply(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), e_mc(0), "mc_start");
      for (int c = 1; c < 10; c++) apply(z, e_mc(0), $sformatf("mc_busy%0d", c));
      apply(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), e_none(0), "mc_done");
      apply(z, e_none(0), "mc_after");

      // Timeout after 34 busy cycles; a memory wait in the middle keeps the count
      apply(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), e_mc(0), "to_start");
      for (int c = 1; c <= 34; c++) begin
         if (c >= 10 && c <= 12)
            apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), e_mem(0), $sformatf("to_memwait%0d", c));
         else if (c == 13)
            apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), e_mc(0), "to_memack");
         else
            apply(z, e_mc(0), $sformatf("to_busy%0d", c));
      end
      apply(z, e_none(1), "to_expired");
      apply(mk_in(5, 0, 1, 0, 1, 5, 0, 0, 0, 0, 0), e_lu(1), "to_sticky_lu");

      // Branch masked by a memory wait takes effect once the wait ends
      for (int c = 0; c < 3; c++)
         apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), e_mem(1), $sformatf("br_memwait%0d", c));
      apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), e_br(1), "br_flush");
      apply(z, e_none(1), "br_after");

      // Reset during MC_BUSY cycle 5
      apply(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), e_mc(1), "rst_mc_start");
      for (int c = 1; c < 5; c++) apply(z, e_mc(1), $sformatf("rst_mc_busy%0d", c));
      @(posedge clk);
      #1;
      drive(mk_in(5, 0, 1, 0, 1, 5, 0, 0, 1, 1, 0));
      #1 rst_n = 1'b0;
      #1;
      sb_q.push_back(e_none(0));
      check("rst_async");
      @(negedge clk);
      sb_q.push_back(e_none(0));
      check("rst_held");
      drive(z);
      #2 rst_n = 1'b1;
      apply(z, e_none(0), "rst_release0");
      apply(z, e_none(0), "rst_release1");
      apply(mk_in(0, 4, 0, 1, 1, 4, 0, 0, 0, 0, 0), e_lu(0), "rst_lu_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
